adder_driver: RTL
=================

# adder_driver

Host-side driver for the `adder` accelerator: the sender of its `a_valid/a_data`, `b_valid/b_data` operand loads and the consumer of its `c_data` result. On `launch` it streams `length` operand pairs from memory, one read at a time, and loads each pair into the adder. It captures each sum and writes it back to memory, then pulses `finish` and reports the cycle count. It sits between the TSIM host/memory model and the adder.

## Interface
- `MEM_DATA_BITS`, 64: word width; must match the adder.
- `MEM_ADDR_BITS`, 64: byte-address width.
- `LEN_BITS`, 32: width of `length` and `cycles`.

- `clock`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-low.
- `launch`  in  1  start pulse; sampled only in IDLE.
- `length`  in  LEN_BITS  element count; latched at launch.
- `a_addr`, `b_addr`, `c_addr`  in  MEM_ADDR_BITS  base byte addresses; latched at launch.
- `finish`  out  1  one-cycle pulse at job end.
- `cycles`  out  LEN_BITS  cycles from launch to finish; holds until next launch.
- `rd_req_valid`  out  1  read request.
- `rd_req_ready`  in  1  memory accepts the request.
- `rd_req_addr`  out  MEM_ADDR_BITS  read address.
- `rd_resp_valid`  in  1  read data valid.
- `rd_resp_data`  in  MEM_DATA_BITS  read data.
- `wr_valid`  out  1  write request.
- `wr_ready`  in  1  memory accepts the write.
- `wr_addr`  out  MEM_ADDR_BITS  write address.
- `wr_data`  out  MEM_DATA_BITS  write data.
- `a_valid`, `b_valid`  out  1  load strobes to the adder.
- `a_data`, `b_data`  out  MEM_DATA_BITS  operands to the adder.
- `c_data`  in  MEM_DATA_BITS  sum from the adder's registered operands.

## Operation
- FSM states: IDLE → RD_A → WAIT_A → RD_B → WAIT_B → ISSUE → CAPTURE → WRITE → (next element: RD_A | all done: DONE) → IDLE.
- IDLE, on `launch`:
  - latch `length` and the three bases; clear the element index and `cycles`.
  - go to DONE if `length`==0, else RD_A.
- RD_A / RD_B:
  - drive `rd_req_valid`=1 with `rd_req_addr` = base + index·(MEM_DATA_BITS/8).
  - hold valid and address stable until `rd_req_ready`, then advance to the matching WAIT state.
- WAIT_A / WAIT_B:
  - wait for `rd_resp_valid`, then register `rd_resp_data` into the A or B operand register.
  - at most one read is outstanding; `rd_resp_valid` in any other state is ignored.
- ISSUE: `a_valid`=`b_valid`=1 for exactly one cycle, with `a_data`/`b_data` = operand registers.
- CAPTURE: one cycle; register `c_data` (the adder's sum is valid the cycle after ISSUE).
- WRITE:
  - drive `wr_valid`=1 with `wr_addr` = c_base + index·bytes and `wr_data` = captured sum.
  - hold until `wr_ready`, then increment the index.
  - go to DONE if index+1 == length, else RD_A.
- DONE: `finish`=1 for one cycle; freeze `cycles`; return to IDLE.
- Address arithmetic: modulo 2^MEM_ADDR_BITS; wrap-around is silent.
- The sum is not computed here; it is whatever the adder returns, modulo 2^MEM_DATA_BITS.
- `launch` outside IDLE is ignored. A `launch` in the same cycle as DONE is also ignored.

## Timing
- Reset (asserted low, asynchronous):
  - state → IDLE.
  - all outputs 0: `finish`, `cycles`, all valids, all addresses, all data.
  - index and operand registers → 0.
- Reset mid-job: aborts immediately; no `finish`; an in-flight read response after reset is ignored.
- `cycles`: increments every cycle from the cycle after launch through the cycle DONE is entered.
- Per element with zero-wait memory (ready and response each the cycle after request): RD_A, WAIT_A, RD_B, WAIT_B, ISSUE, CAPTURE, WRITE = 7 cycles.
- Valid signals are registered outputs: no combinational path from `rd_req_ready`/`wr_ready` to any output.

## Structure
- Package `adder_driver_pkg`:
  - state enum `adder_driver_state_t`.
  - function `bytes_per_word(MEM_DATA_BITS)`.
- Sub-module `adder_driver_addr_gen`:
  - latches the three bases.
  - outputs read-A, read-B and write addresses from the shared index.
- The FSM, operand/sum registers and cycle counter live in the top level.

## Test plan
- Single element, zero-wait memory:
  - stimulus: `length`=1, A=5, B=7.
  - response: reads at `a_addr`, then `b_addr`; `a_valid` and `b_valid` high in the same cycle; write of 12 to `c_addr`; `finish` pulses once.
- Four elements with random `rd_req_ready`/`wr_ready` stalls:
  - stimulus: A={1,2,3,4}, B={10,20,30,40}.
  - response: C={11,22,33,44} at `c_addr`+{0,8,16,24}; requests stay stable while stalled.
- `length`=0: `finish` pulses exactly 2 cycles after launch, with no memory or adder traffic and `cycles`=1.
- Overflow and wrap:
  - stimulus: A=2^64−1, B=2; `c_addr`=2^64−8 with `length`=2.
  - response: written data=1; second write address=0.
- Reset asserted during WAIT_B of element 2 of 4: all outputs 0 asynchronously; no `finish`; a relaunch completes correctly.
- `launch` pulsed during WRITE: ignored; `length` and bases unchanged; exactly one `finish`.

Source files
------------

// File: rtl/adder_driver_pkg.sv
// Shared types and helpers for the adder host-side driver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package adder_driver_pkg;

  localparam int DEF_MEM_DATA_BITS = 64;
  localparam int DEF_MEM_ADDR_BITS = 64;
  localparam int DEF_LEN_BITS      = 32;

  // One state per memory/adder phase of an element, plus job bookends.
  typedef enum logic [3:0] {
    IDLE,
    RD_A,
    WAIT_A,
    RD_B,
    WAIT_B,
    ISSUE,
    CAPTURE,
    WRITE,
    DONE
  } adder_driver_state_t;

  // Byte stride between consecutive elements in memory.
  function automatic int bytes_per_word(input int data_bits);
    return data_bits / 8;
  endfunction

endpackage

// File: rtl/adder_driver_if.sv
// Bundles the host control, memory read/write and adder operand/result signals.
// Latency: n/a (wiring only).
// Backpressure: rd_req_ready / wr_ready throttle the driver; the adder has none.
interface adder_driver_if
  import adder_driver_pkg::*;
#(
  parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS,
  parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
  parameter int LEN_BITS      = DEF_LEN_BITS
);

  // host control
  logic                     launch;
  logic [LEN_BITS-1:0]      length;
  logic [MEM_ADDR_BITS-1:0] a_addr;
  logic [MEM_ADDR_BITS-1:0] b_addr;
  logic [MEM_ADDR_BITS-1:0] c_addr;
  logic                     finish;
  logic [LEN_BITS-1:0]      cycles;

  // memory read channel
  logic                     rd_req_valid;
  logic                     rd_req_ready;
  logic [MEM_ADDR_BITS-1:0] rd_req_addr;
  logic                     rd_resp_valid;
  logic [MEM_DATA_BITS-1:0] rd_resp_data;

  // memory write channel
  logic                     wr_valid;
  logic                     wr_ready;
  logic [MEM_ADDR_BITS-1:0] wr_addr;
  logic [MEM_DATA_BITS-1:0] wr_data;

  // adder operands and result
  logic                     a_valid;
  logic                     b_valid;
  logic [MEM_DATA_BITS-1:0] a_data;
  logic [MEM_DATA_BITS-1:0] b_data;
  logic [MEM_DATA_BITS-1:0] c_data;

  // The driver side
  modport master (
    input  launch, length, a_addr, b_addr, c_addr,
    output finish, cycles,
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready, rd_resp_valid, rd_resp_data,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output a_valid, b_valid, a_data, b_data,
    input  c_data
  );

  // The environment side: host, memory model and adder
  modport slave (
    output launch, length, a_addr, b_addr, c_addr,
    input  finish, cycles,
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready, rd_resp_valid, rd_resp_data,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  a_valid, b_valid, a_data, b_data,
    output c_data
  );

endinterface

// File: rtl/adder_driver_addr_gen.sv
// Latches the three base addresses and forms base + idx*stride for each stream.
// Latency: combinational from idx; bases pass straight through on the load cycle.
// Backpressure: none; the caller decides when the addresses are used.
module adder_driver_addr_gen #(
  parameter int MEM_ADDR_BITS = 64,
  parameter int LEN_BITS      = 32,
  parameter int BYTES         = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic [MEM_ADDR_BITS-1:0] a_base_in,
  input  logic [MEM_ADDR_BITS-1:0] b_base_in,
  input  logic [MEM_ADDR_BITS-1:0] c_base_in,
  input  logic [LEN_BITS-1:0]      idx,
  output logic [MEM_ADDR_BITS-1:0] rd_a_addr,
  output logic [MEM_ADDR_BITS-1:0] rd_b_addr,
  output logic [MEM_ADDR_BITS-1:0] wr_addr
);

  logic [MEM_ADDR_BITS-1:0] a_base;
  logic [MEM_ADDR_BITS-1:0] b_base;
  logic [MEM_ADDR_BITS-1:0] c_base;
  logic [MEM_ADDR_BITS-1:0] a_sel;
  logic [MEM_ADDR_BITS-1:0] b_sel;
  logic [MEM_ADDR_BITS-1:0] c_sel;
  logic [MEM_ADDR_BITS-1:0] offset;

  // Capture the job's bases when a launch is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_base <= '0;
      b_base <= '0;
      c_base <= '0;
    end else if (load) begin
      a_base <= a_base_in;
      b_base <= b_base_in;
      c_base <= c_base_in;
    end
  end

  // On the launch cycle the registers are not yet loaded, so use the inputs
  // directly; the first request address is registered in that same cycle.
  always_comb begin
    a_sel     = load ? a_base_in : a_base;
    b_sel     = load ? b_base_in : b_base;
    c_sel     = load ? c_base_in : c_base;
    offset    = MEM_ADDR_BITS'(idx) * MEM_ADDR_BITS'(BYTES);
    rd_a_addr = a_sel + offset;
    rd_b_addr = b_sel + offset;
    wr_addr   = c_sel + offset;
  end

endmodule

// File: rtl/adder_driver.sv
// Streams length operand pairs from memory into the adder and writes each sum back.
// Latency: 7 cycles per element with zero-wait memory, plus one DONE cycle per job.
// Backpressure: holds read/write requests stable until rd_req_ready / wr_ready.
module adder_driver
  import adder_driver_pkg::*;
#(
  parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS,
  parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
  parameter int LEN_BITS      = DEF_LEN_BITS
) (
  input  logic             clock,
  input  logic             reset,
  adder_driver_if.master   bus
);

  localparam int BYTES = bytes_per_word(MEM_DATA_BITS);

  adder_driver_state_t      state;
  logic [LEN_BITS-1:0]      len_q;
  logic [LEN_BITS-1:0]      idx_q;
  logic [LEN_BITS-1:0]      idx_inc;
  logic [LEN_BITS-1:0]      addr_idx;
  logic [MEM_DATA_BITS-1:0] op_a;
  logic [MEM_DATA_BITS-1:0] op_b;
  logic [MEM_DATA_BITS-1:0] sum_q;
  logic [LEN_BITS-1:0]      cycles_q;
  logic                     finish_q;
  logic                     rd_req_valid_q;
  logic [MEM_ADDR_BITS-1:0] rd_req_addr_q;
  logic                     wr_valid_q;
  logic [MEM_ADDR_BITS-1:0] wr_addr_q;
  logic                     ab_valid_q;
  logic                     load;
  logic [MEM_ADDR_BITS-1:0] gen_rd_a;
  logic [MEM_ADDR_BITS-1:0] gen_rd_b;
  logic [MEM_ADDR_BITS-1:0] gen_wr;

  // Addresses are registered on entry to the request state, so WRITE must look
  // one element ahead for the next A read; IDLE always starts at element 0.
  always_comb begin
    load     = (state == IDLE) && bus.launch;
    idx_inc  = idx_q + LEN_BITS'(1);
    addr_idx = idx_q;
    if (state == IDLE) addr_idx = '0;
    else if (state == WRITE) addr_idx = idx_inc;
  end

  adder_driver_addr_gen #(
    .MEM_ADDR_BITS (MEM_ADDR_BITS),
    .LEN_BITS      (LEN_BITS),
    .BYTES         (BYTES)
  ) u_addr_gen (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .a_base_in (bus.a_addr),
    .b_base_in (bus.b_addr),
    .c_base_in (bus.c_addr),
    .idx       (addr_idx),
    .rd_a_addr (gen_rd_a),
    .rd_b_addr (gen_rd_b),
    .wr_addr   (gen_wr)
  );

  // Job FSM: every output is a register set on entry to the state that owns it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      len_q          <= '0;
      idx_q          <= '0;
      op_a           <= '0;
      op_b           <= '0;
      sum_q          <= '0;
      cycles_q       <= '0;
      finish_q       <= 1'b0;
      rd_req_valid_q <= 1'b0;
      rd_req_addr_q  <= '0;
      wr_valid_q     <= 1'b0;
      wr_addr_q      <= '0;
      ab_valid_q     <= 1'b0;
    end else begin
      finish_q   <= 1'b0;
      ab_valid_q <= 1'b0;
      if (state != IDLE) cycles_q <= cycles_q + LEN_BITS'(1);
      case (state)
        IDLE: begin
          if (bus.launch) begin
            len_q    <= bus.length;
            idx_q    <= '0;
            cycles_q <= '0;
            if (bus.length == '0) begin
              state <= DONE;
            end else begin
              state          <= RD_A;
              rd_req_valid_q <= 1'b1;
              rd_req_addr_q  <= gen_rd_a;
            end
          end
        end
        RD_A: begin
          if (bus.rd_req_ready) begin
            rd_req_valid_q <= 1'b0;
            state          <= WAIT_A;
          end
        end
        WAIT_A: begin
          if (bus.rd_resp_valid) begin
            op_a           <= bus.rd_resp_data;
            rd_req_valid_q <= 1'b1;
            rd_req_addr_q  <= gen_rd_b;
            state          <= RD_B;
          end
        end
        RD_B: begin
          if (bus.rd_req_ready) begin
            rd_req_valid_q <= 1'b0;
            state          <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bus.rd_resp_valid) begin
            op_b       <= bus.rd_resp_data;
            ab_valid_q <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          // The adder's registered sum is visible the cycle after ISSUE.
          sum_q      <= bus.c_data;
          wr_valid_q <= 1'b1;
          wr_addr_q  <= gen_wr;
          state      <= WRITE;
        end
        WRITE: begin
          if (bus.wr_ready) begin
            wr_valid_q <= 1'b0;
            idx_q      <= idx_inc;
            if (idx_inc == len_q) begin
              state <= DONE;
            end else begin
              state          <= RD_A;
              rd_req_valid_q <= 1'b1;
              rd_req_addr_q  <= gen_rd_a;
            end
          end
        end
        DONE: begin
          finish_q <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.finish       = finish_q;
  assign bus.cycles       = cycles_q;
  assign bus.rd_req_valid = rd_req_valid_q;
  assign bus.rd_req_addr  = rd_req_addr_q;
  assign bus.wr_valid     = wr_valid_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = sum_q;
  assign bus.a_valid      = ab_valid_q;
  assign bus.b_valid      = ab_valid_q;
  assign bus.a_data       = op_a;
  assign bus.b_data       = op_b;

endmodule
